shift_unit_pipe: RTL and testbench

- Parametrised, pipelined successor to the single-cycle SHIFT ALU slice.
- Performs logical, arithmetic and rotate shifts on WIDTH-bit data, with a signed shift amount:
  - positive amount → left,
  - negative amount → right.
- Adds mode select, saturation rules, shifted-out carry, zero flag and valid/ready handshakes on both sides.
- Sits in the execute stage; fed by the decode immediate, drained by writeback.

---
 rtl/shift_pkg.sv | 44 ++++
 rtl/shift_pipe_stage.sv | 94 +++++++++
 rtl/shift_unit_pipe.sv | 124 ++++++++++++
 tb/tb_shift_unit_pipe.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared types for the pipelined shift unit:
// mode encodings, control bundle, layer split.
package shift_pkg;

  typedef enum logic [1:0] {
    SHM_LOGIC = 2'b00,
    SHM_ARITH = 2'b01,
    SHM_ROT   = 2'b10,
    SHM_PASS  = 2'b11
  } shmode_t;

  // Control bits riding alongside the data.
  typedef struct packed {
    shmode_t mode;
    logic    dir;
    logic    ovf;
    logic    sign;
    logic    rnz;
    logic    carry;
    logic    zero;
  } shctl_t;

  // Barrel layers held by stage k; the
  // earliest stages take the extra layer.
  function automatic int lay_cnt(
    input int k,
    input int stages,
    input int layers
  );
    return layers / stages +
      ((k < layers % stages) ? 1 : 0);
  endfunction

  function automatic int lay_first(
    input int k,
    input int stages,
    input int layers
  );
    return k * (layers / stages) +
      ((k < layers % stages) ?
        k : layers % stages);
  endfunction

endpackage

// File: rtl/shift_pipe_stage.sv
// One register slice of the shift pipe with its barrel layers.
// up_* accept side, dn_* registered side, valid/ready on both.
module shift_pipe_stage
  import shift_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int LOG   = 4,
  parameter int FIRST = 0,
  parameter int NLAY  = 2,
  parameter bit LAST  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [WIDTH-1:0] up_data,
  input  logic [LOG-1:0]   up_amt,
  input  shctl_t           up_ctl,
  output logic             dn_valid,
  input  logic             dn_ready,
  output logic [WIDTH-1:0] dn_data,
  output logic [LOG-1:0]   dn_amt,
  output shctl_t           dn_ctl
);

  logic             adv;
  logic [WIDTH-1:0] d;
  shctl_t           nxt;

  function automatic logic [WIDTH-1:0] layer(
    input logic [WIDTH-1:0] v,
    input int               s,
    input shctl_t           c
  );
    logic [WIDTH-1:0] r;
    unique case (c.mode)
      SHM_ROT:
        r = c.dir ?
          ((v >> s) | (v << (WIDTH - s))) :
          ((v << s) | (v >> (WIDTH - s)));
      SHM_ARITH:
        r = c.dir ?
          WIDTH'($signed(v) >>> s) :
          (v << s);
      default:
        r = c.dir ? (v >> s) : (v << s);
    endcase
    return r;
  endfunction

  assign adv      = !dn_valid || dn_ready;
  assign up_ready = adv;

  always_comb begin
    d   = up_data;
    nxt = up_ctl;
    for (int i = 0; i < LOG; i++) begin
      if (i >= FIRST && i < FIRST + NLAY &&
          up_amt[i])
        d = layer(d, 1 << i, up_ctl);
    end
    if (LAST) begin
      // Oversized logical/arith shifts
      // saturate to fill pattern.
      if (up_ctl.ovf &&
          (up_ctl.mode == SHM_LOGIC ||
           up_ctl.mode == SHM_ARITH))
        d = (up_ctl.mode == SHM_ARITH &&
             up_ctl.dir && up_ctl.sign) ?
          '1 : '0;
      if (up_ctl.mode == SHM_ROT)
        nxt.carry = up_ctl.rnz &
          (up_ctl.dir ? d[WIDTH-1] : d[0]);
      nxt.zero = (d == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dn_valid <= 1'b0;
      dn_data  <= '0;
      dn_amt   <= '0;
      dn_ctl   <= '0;
    end else if (adv) begin
      dn_valid <= up_valid;
      if (up_valid) begin
        dn_data <= d;
        dn_amt  <= up_amt;
        dn_ctl  <= nxt;
      end
    end
  end

endmodule

// File: rtl/shift_unit_pipe.sv
// Pipelined logical/arith/rotate shifter, signed amount.
// in_* request handshake, out_* result with carry and zero.
module shift_unit_pipe
  import shift_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int AMT_W  = 5,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic             out_zero
);

  localparam int LOG = $clog2(WIDTH);

  logic             v   [STAGES+1];
  logic             rdy [STAGES+1];
  logic [WIDTH-1:0] dat [STAGES+1];
  logic [LOG-1:0]   amt [STAGES+1];
  shctl_t           ctl [STAGES+1];

  shmode_t          mode;
  logic             dir;
  logic [AMT_W-1:0] n;
  int               n_i;
  logic [LOG-1:0]   shamt;
  logic             lin_carry;

  assign mode = shmode_t'(in_mode);
  assign dir  = in_amt[AMT_W-1];
  // Most negative amount wraps to
  // 2^(AMT_W-1) as an unsigned value.
  assign n    = dir ? AMT_W'(-in_amt) : in_amt;
  assign n_i  = int'(n);

  always_comb begin
    shamt = LOG'(n_i);
    if (mode == SHM_PASS)
      shamt = '0;
  end

  // Carry for the non-rotate modes is known
  // from the operand before any layer.
  always_comb begin
    lin_carry = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (!dir && n_i == WIDTH - i)
        lin_carry = in_data[i];
      if (dir && n_i == i + 1)
        lin_carry = in_data[i];
    end
    if (n_i > WIDTH && dir &&
        mode == SHM_ARITH)
      lin_carry = in_data[WIDTH-1];
    if (mode == SHM_ROT ||
        mode == SHM_PASS)
      lin_carry = 1'b0;
  end

  always_comb begin
    ctl[0]       = '0;
    ctl[0].mode  = mode;
    ctl[0].dir   = dir;
    ctl[0].ovf   = (mode != SHM_PASS) &&
                   (n_i >= WIDTH);
    ctl[0].sign  = in_data[WIDTH-1];
    ctl[0].rnz   = (mode == SHM_ROT) &&
                   (shamt != '0);
    ctl[0].carry = lin_carry;
  end

  assign v[0]        = in_valid;
  assign dat[0]      = in_data;
  assign amt[0]      = shamt;
  assign rdy[STAGES] = out_ready;
  assign in_ready    = rdy[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    shift_pipe_stage #(
      .WIDTH (WIDTH),
      .LOG   (LOG),
      .FIRST (lay_first(k, STAGES, LOG)),
      .NLAY  (lay_cnt(k, STAGES, LOG)),
      .LAST  (k == STAGES - 1)
    ) u_st (
      .clk      (clk),
      .rst_n    (rst_n),
      .up_valid (v[k]),
      .up_ready (rdy[k]),
      .up_data  (dat[k]),
      .up_amt   (amt[k]),
      .up_ctl   (ctl[k]),
      .dn_valid (v[k+1]),
      .dn_ready (rdy[k+1]),
      .dn_data  (dat[k+1]),
      .dn_amt   (amt[k+1]),
      .dn_ctl   (ctl[k+1])
    );
  end

  assign out_valid = v[STAGES];
  assign out_data  = dat[STAGES];
  assign out_carry = ctl[STAGES].carry;
  assign out_zero  = ctl[STAGES].zero;

  logic unused;
  assign unused = ^{amt[STAGES],
                    ctl[STAGES].mode,
                    ctl[STAGES].dir,
                    ctl[STAGES].ovf,
                    ctl[STAGES].sign,
                    ctl[STAGES].rnz};

endmodule

// File: tb/tb_shift_unit_pipe.sv
// Bench for shift_unit_pipe: directed cases plus
// randomized traffic against a spec-level model.
module tb_shift_unit_pipe;

  localparam int W  = 16;
  localparam int AW = 5;
  localparam int ST = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic [AW-1:0] in_amt = '0;
  logic [1:0]    in_mode = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_data;
  logic          out_carry;
  logic          out_zero;

  shift_unit_pipe #(
    .WIDTH(W), .AMT_W(AW), .STAGES(ST)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_carry (out_carry),
    .out_zero  (out_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] d;
    logic         c;
    logic         z;
    int           cyc;
  } exp_t;

  exp_t         q[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  bit           lat_chk = 1'b0;
  bit           rnd_or = 1'b0;
  logic [W-1:0] exp_d;
  logic         exp_c;
  logic         exp_z;
  bit           hold_v = 1'b0;
  logic [W-1:0] hold_d;
  logic         hold_c;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h",
               tag, got, exp);
    end
  endtask

  // Spec-level reference: {result, carry, zero}.
  function automatic logic [W+1:0] model(
    input logic [W-1:0]  d,
    input logic [AW-1:0] a,
    input logic [1:0]    m
  );
    int           n;
    int           k;
    bit           right;
    logic [W-1:0] r;
    logic         c;
    right = a[AW-1];
    n = right ? (1 << AW) - int'(a) : int'(a);
    r = d;
    c = 1'b0;
    if (m == 2'b10) begin
      k = n % W;
      if (k != 0) begin
        if (right) r = (d >> k) | (d << (W - k));
        else       r = (d << k) | (d >> (W - k));
        c = right ? r[W-1] : r[0];
      end
    end else if (m != 2'b11 && n != 0) begin
      if (!right)
        r = (n >= W) ? '0 : (d << n);
      else if (m == 2'b00)
        r = (n >= W) ? '0 : (d >> n);
      else
        r = (n >= W) ? {W{d[W-1]}} :
            W'($signed(d) >>> n);
      if (n <= W)
        c = right ? d[n-1] : d[W-n];
      else
        c = (m == 2'b01 && right) ? d[W-1] : 1'b0;
    end
    return {r, c, (r == '0)};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard and hold monitor, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      q.delete();
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        check("hold_valid", {31'b0, out_valid}, 1);
        check("hold_data", {16'b0, out_data},
              {16'b0, hold_d});
        check("hold_carry", {31'b0, out_carry},
              {31'b0, hold_c});
      end
      hold_v = out_valid && !out_ready;
      hold_d = out_data;
      hold_c = out_carry;
      if (in_valid && in_ready) begin
        e.d = exp_d; e.c = exp_c;
        e.z = exp_z; e.cyc = cyc;
        q.push_back(e);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("spurious_out", {31'b0, out_valid}, 0);
        end else begin
          e = q.pop_front();
          check("data", {16'b0, out_data},
                {16'b0, e.d});
          check("carry", {31'b0, out_carry},
                {31'b0, e.c});
          check("zero", {31'b0, out_zero},
                {31'b0, e.z});
          if (lat_chk)
            check("latency", cyc - e.cyc, ST);
        end
      end
    end
  end

  task automatic send(
    input logic [W-1:0]  d,
    input logic [AW-1:0] a,
    input logic [1:0]    m,
    input logic [W-1:0]  ed,
    input logic          ec,
    input logic          ez
  );
    bit took = 1'b0;
    in_data = d; in_amt = a; in_mode = m;
    exp_d = ed; exp_c = ec; exp_z = ez;
    in_valid = 1'b1;
    for (int i = 0; i < 200 && !took; i++) begin
      @(negedge clk);
      took = in_ready;
      @(posedge clk);
      #1;
      if (rnd_or) out_ready = ($urandom % 4) != 0;
    end
    in_valid = 1'b0;
    if (!took) check("accept_timeout", 0, 1);
  endtask

  task automatic send_m(
    input logic [W-1:0]  d,
    input logic [AW-1:0] a,
    input logic [1:0]    m
  );
    logic [W+1:0] r;
    r = model(d, a, m);
    send(d, a, m, r[W+1:2], r[1], r[0]);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 100 && q.size() != 0; i++)
      @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    check("drain_empty", q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {31'b0, out_valid}, 0);
    check("rst_out_data", {16'b0, out_data}, 0);
    check("rst_out_zero", {31'b0, out_zero}, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", {31'b0, in_ready}, 1);
    check("idle_out_valid", {31'b0, out_valid}, 0);

    // Directed cases, back to back, no stall.
    lat_chk = 1'b1;
    send(16'h00F1, 5'd4,  2'b00, 16'h0F10, 0, 0);
    send(16'h800F, 5'h1C, 2'b00, 16'h0800, 1, 0);
    send(16'h8000, 5'h10, 2'b01, 16'hFFFF, 1, 0);
    send(16'h8000, 5'h10, 2'b00, 16'h0000, 1, 1);
    send(16'h0001, 5'h1F, 2'b10, 16'h8000, 1, 0);
    send(16'h0001, 5'd15, 2'b10, 16'h8000, 0, 0);
    send(16'h1234, 5'h10, 2'b10, 16'h1234, 0, 0);
    send(16'hABCD, 5'd7,  2'b11, 16'hABCD, 0, 0);
    send(16'h0000, 5'd3,  2'b01, 16'h0000, 0, 1);
    drain();
    lat_chk = 1'b0;

    // Backpressure: two entries fill the pipe.
    out_ready = 1'b0;
    send(16'h0001, 5'd1, 2'b00, 16'h0002, 0, 0);
    send(16'h0001, 5'd2, 2'b00, 16'h0004, 0, 0);
    check("bp_in_ready", {31'b0, in_ready}, 0);
    @(posedge clk);
    #1;
    check("bp_in_ready2", {31'b0, in_ready}, 0);
    check("bp_out_data", {16'b0, out_data}, 16'h0002);
    out_ready = 1'b1;
    send(16'h0001, 5'd3, 2'b00, 16'h0008, 0, 0);
    send(16'h0001, 5'd4, 2'b00, 16'h0010, 0, 0);
    drain();

    // Async reset with two entries in flight.
    send(16'h0003, 5'd1, 2'b00, 16'h0006, 0, 0);
    send(16'h0003, 5'd2, 2'b00, 16'h000C, 0, 0);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", {31'b0, out_valid}, 0);
    check("arst_out_data", {16'b0, out_data}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_rst_idle", {31'b0, out_valid}, 0);
    end
    @(posedge clk);
    #1;
    send_m(16'h00FF, 5'd8, 2'b00);
    drain();

    // Randomized traffic with random stalls.
    rnd_or = 1'b1;
    for (int i = 0; i < 400; i++) begin
      logic [W-1:0] d;
      d = ($urandom % 8 == 0) ? '0 : W'($urandom);
      send_m(d, AW'($urandom), 2'($urandom));
      if ($urandom % 5 == 0) begin
        @(posedge clk);
        #1;
        out_ready = ($urandom % 4) != 0;
      end
    end
    rnd_or = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
